// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        JUMP = 2'd2,
        RET  = 2'd3
    } trap_state_t;

    // Reserved mtvec modes (2, 3) collapse to direct mode.
    function automatic logic [1:0] mtvec_mode_warl(input logic [1:0] mode);
        return mode[1] ? 2'b00 : mode;
    endfunction

endpackage

// File: rtl/trap_csr_regs.sv
// Trap CSR storage (mstatus MIE/MPIE, mie, mip, mtvec, mepc, mcause), WARL masking, read mux.
// Latency: writes and trap updates land on the next edge; mip lags the irq lines by one cycle; reads are combinational.
// Backpressure: none; the sequencer gates writes so they never collide with trap entry or mret.
module trap_csr_regs
    import trap_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            trap_save,
    input  logic [XLEN-1:0] save_pc,
    input  logic [3:0]      save_code,
    input  logic            trap_ret,
    output logic [XLEN-1:0] rdata,
    output logic            status_mie,
    output logic            ext_pend,
    output logic            tmr_pend,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic [3:0]      cause_code
);

    logic            status_mpie;
    logic            en_ext;
    logic            en_tmr;
    logic            ip_ext;
    logic            ip_tmr;
    logic [XLEN-1:0] mcause;

    assign ext_pend   = ip_ext & en_ext;
    assign tmr_pend   = ip_tmr & en_tmr;
    assign cause_code = mcause[3:0];

    // Register the interrupt lines into mip every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ip_ext <= 1'b0;
            ip_tmr <= 1'b0;
        end else begin
            ip_ext <= ext_irq;
            ip_tmr <= timer_irq;
        end
    end

    // Trap entry, mret and software writes; the caller guarantees at most one is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            en_ext      <= 1'b0;
            en_tmr      <= 1'b0;
            mtvec       <= MTVEC_RESET;
            mepc        <= '0;
            mcause      <= '0;
        end else if (trap_save) begin
            mepc        <= save_pc & ~XLEN'(3);
            mcause      <= {1'b1, {(XLEN-5){1'b0}}, save_code};
            status_mpie <= status_mie;
            status_mie  <= 1'b0;
        end else if (trap_ret) begin
            status_mie  <= status_mpie;
            status_mpie <= 1'b1;
        end else if (wr_en) begin
            case (addr)
                CSR_MSTATUS: begin
                    status_mie  <= wdata[3];
                    status_mpie <= wdata[7];
                end
                CSR_MIE: begin
                    en_ext <= wdata[11];
                    en_tmr <= wdata[7];
                end
                CSR_MTVEC:  mtvec  <= {wdata[XLEN-1:2], mtvec_mode_warl(wdata[1:0])};
                CSR_MEPC:   mepc   <= wdata & ~XLEN'(3);
                CSR_MCAUSE: mcause <= wdata;
                default: ;
            endcase
        end
    end

    // Read mux: zero when not reading or for unimplemented addresses.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                CSR_MSTATUS: begin
                    rdata[3] = status_mie;
                    rdata[7] = status_mpie;
                end
                CSR_MIE: begin
                    rdata[11] = en_ext;
                    rdata[7]  = en_tmr;
                end
                CSR_MIP: begin
                    rdata[11] = ip_ext;
                    rdata[7]  = ip_tmr;
                end
                CSR_MTVEC:  rdata = mtvec;
                CSR_MEPC:   rdata = mepc;
                CSR_MCAUSE: rdata = mcause;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode interrupt/mret sequencer: takes irqs on the execute instruction, runs mret, redirects fetch.
// Latency: take cycle -> SAVE (flush+stall) -> JUMP (redirect to vector); mret -> RET redirect on the next cycle.
// Backpressure: holds the pipeline with stall during SAVE; ignores new irqs, mret and CSR writes while not IDLE.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            is_mret,
    input  logic            csr_wr,
    input  logic            csr_rd,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            flush,
    output logic            stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_active
);

    trap_state_t     state;
    trap_state_t     state_nxt;
    logic            status_mie;
    logic            ext_pend;
    logic            tmr_pend;
    logic            take;
    logic            csr_we;
    logic [3:0]      take_code;
    logic [3:0]      cause_code;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] vec_pc;

    // Interrupts win over a same-cycle mret; the trapped instruction's CSR write is dropped.
    assign take      = (state == IDLE) & status_mie & (ext_pend | tmr_pend) & ex_valid;
    assign take_code = ext_pend ? CAUSE_MEI : CAUSE_MTI;
    assign csr_we    = csr_wr & (state == IDLE) & ~take;

    // Vectored mode offsets the base by 4*cause; mcause is stable while the sequence runs.
    assign vec_pc = {mtvec[XLEN-1:2], 2'b00}
                  + ((mtvec[1:0] == 2'b01) ? XLEN'({cause_code, 2'b00}) : '0);

    trap_csr_regs #(
        .XLEN        (XLEN),
        .MTVEC_RESET (MTVEC_RESET)
    ) u_regs (
        .clk        (clk),
        .rst        (rst),
        .ext_irq    (ext_irq),
        .timer_irq  (timer_irq),
        .wr_en      (csr_we),
        .rd_en      (csr_rd),
        .addr       (csr_addr),
        .wdata      (csr_wdata),
        .trap_save  (take),
        .save_pc    (ex_pc),
        .save_code  (take_code),
        .trap_ret   (state == RET),
        .rdata      (csr_rdata),
        .status_mie (status_mie),
        .ext_pend   (ext_pend),
        .tmr_pend   (tmr_pend),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .cause_code (cause_code)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pipeline control outputs.
    always_comb begin
        state_nxt   = state;
        flush       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        trap_active = (state != IDLE);
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = SAVE;
                end else if (is_mret && ex_valid) begin
                    state_nxt = RET;
                end
            end
            SAVE: begin
                flush     = 1'b1;
                stall     = 1'b1;
                state_nxt = JUMP;
            end
            JUMP: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = vec_pc;
                state_nxt   = IDLE;
            end
            RET: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = mepc;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
